// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: req/fin read/write port bundle; master issues requests, slave completes them
interface sdram_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              wr_req;
  logic              rd_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              wr_fin;
  logic              rd_fin;
  modport master(output wr_req, rd_req, wr_addr, rd_addr, wr_data, input rd_data, wr_fin, rd_fin);
  modport slave(input wr_req, rd_req, wr_addr, rd_addr, wr_data, output rd_data, wr_fin, rd_fin);
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: serialises IF (p0) and MEM (p1) accesses onto one SDRAM req/fin port.
// SDRAM_ARB_RR_EN selects round-robin arbitration; otherwise p1 wins every tie.
module sdram_arbiter (
  input  logic clk,
  input  logic reset,
  sdram_arbiter_if.slave  p0,
  sdram_arbiter_if.slave  p1,
  sdram_arbiter_if.master sdram,
  output logic busy,
  output logic grant
);
  typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;
  state_t state, state_n;
  logic any0, any1, pick, sel, wsel, wr_done, rd_done;
`ifdef SDRAM_ARB_RR_EN
  logic ptr;
`endif
  always_comb begin
    any0 = p0.wr_req | p0.rd_req;
    any1 = p1.wr_req | p1.rd_req;
    pick = any0 | any1;
`ifdef SDRAM_ARB_RR_EN
    sel = (any0 & any1) ? ptr : any1;
`else
    sel = any1;
`endif
    wsel = sel ? p1.wr_req : p0.wr_req;
    wr_done = state == WR && sdram.wr_fin;
    rd_done = state == RD && sdram.rd_fin;
    state_n = state == IDLE ? (pick ? (wsel ? WR : RD) : IDLE) :
              state == WR   ? (sdram.wr_fin ? FIN : WR) :
              state == RD   ? (sdram.rd_fin ? FIN : RD) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= 1'b0;
      sdram.wr_req  <= 1'b0;
      sdram.rd_req  <= 1'b0;
      sdram.wr_addr <= '0;
      sdram.rd_addr <= '0;
      sdram.wr_data <= '0;
      p0.wr_fin     <= 1'b0;
      p1.wr_fin     <= 1'b0;
      p0.rd_fin     <= 1'b0;
      p1.rd_fin     <= 1'b0;
      p0.rd_data    <= '0;
      p1.rd_data    <= '0;
`ifdef SDRAM_ARB_RR_EN
      ptr           <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      sdram.wr_req <= state_n == WR;
      sdram.rd_req <= state_n == RD;
      p0.wr_fin    <= wr_done & ~grant;
      p1.wr_fin    <= wr_done & grant;
      p0.rd_fin    <= rd_done & ~grant;
      p1.rd_fin    <= rd_done & grant;
      // latch only the side of the granted port that the access will use
      if (state == IDLE && pick) begin
        grant <= sel;
        if (wsel) begin
          sdram.wr_addr <= sel ? p1.wr_addr : p0.wr_addr;
          sdram.wr_data <= sel ? p1.wr_data : p0.wr_data;
        end else
          sdram.rd_addr <= sel ? p1.rd_addr : p0.rd_addr;
      end
      if (rd_done && !grant) p0.rd_data <= sdram.rd_data;
      if (rd_done && grant) p1.rd_data <= sdram.rd_data;
`ifdef SDRAM_ARB_RR_EN
      if (wr_done || rd_done) ptr <= ~grant;
`endif
    end
  end
  assign busy = state != IDLE;
endmodule
